multi_cycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multi-cycle MIPS-subset core.
- Sits directly upstream of the datapath's 8:1 32-bit selectors and drives their 3-bit selects, register/PC/IR write enables, ALU op and memory request.
- Consumes the IR opcode/funct fields, the ALU zero flag and a memory ready handshake.

---
 rtl/multi_cycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Main control FSM for the multi-cycle MIPS-subset core. Drives the 3-bit
// selects of the datapath's 8:1 selectors, the PC/IR/register/MDR write
// enables, the ALU operation and the memory request.
//
// Ports
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   io_opcode     IR[31:26]
//   io_funct      IR[5:0]
//   io_zero       ALU zero flag (same cycle as the ALU result)
//   io_mem_ready  memory completes the current request this cycle
//   io_pc_sel     0 ALU result, 1 ALUOut, 2 jump target, 3 reg A, 4 exc vector
//   io_alu_a_sel  0 PC, 1 reg A
//   io_alu_b_sel  0 reg B, 1 const 4, 2 sext imm, 3 sext imm<<2, 4 zext imm
//   io_wb_sel     0 ALUOut, 1 MDR, 2 PC
//   io_dst_sel    0 rt, 1 rd, 2 r31
//   io_alu_op     0 ADD, 1 SUB, 2 R-type funct decode
//   io_iord       0 address = PC, 1 address = ALUOut
//   io_mem_req    memory request
//   io_mem_we     memory write
//   io_ir_we, io_pc_we, io_reg_we, io_mdr_we   write enables
//   io_illegal    one-cycle pulse in the trap state
//   io_state      current state (debug)
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter bit         EXC_ENABLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] io_opcode,
    input  logic [5:0] io_funct,
    input  logic       io_zero,
    input  logic       io_mem_ready,
    output logic [2:0] io_pc_sel,
    output logic [2:0] io_alu_a_sel,
    output logic [2:0] io_alu_b_sel,
    output logic [2:0] io_wb_sel,
    output logic [2:0] io_dst_sel,
    output logic [3:0] io_alu_op,
    output logic       io_iord,
    output logic       io_mem_req,
    output logic       io_mem_we,
    output logic       io_ir_we,
    output logic       io_pc_we,
    output logic       io_reg_we,
    output logic       io_mdr_we,
    output logic       io_illegal,
    output logic [3:0] io_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // Moore part of the control word, registered alongside the state.
    typedef struct packed {
        logic [2:0] pc_sel;
        logic [2:0] alu_a_sel;
        logic [2:0] alu_b_sel;
        logic [2:0] wb_sel;
        logic [2:0] dst_sel;
        logic [3:0] alu_op;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       pc_we;
        logic       reg_we;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam state_t RESET_S = state_t'(RESET_STATE);

    // Control word seen while the FSM sits in state s. Opcode/funct only
    // matter for JUMP, where IR is stable.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op,
                                          input logic [5:0] fn);
        ctrl_t c;
        c = {$bits(ctrl_t){1'b0}};
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_b_sel = 3'd1;
            end
            S_DECODE: c.alu_b_sel = 3'd3;
            S_MEMADR: begin
                c.alu_a_sel = 3'd1;
                c.alu_b_sel = 3'd2;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_we = 1'b1;
                c.wb_sel = 3'd1;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_EXEC: begin
                c.alu_a_sel = 3'd1;
                c.alu_op    = 4'd2;
            end
            S_RWB: begin
                c.reg_we  = 1'b1;
                c.dst_sel = 3'd1;
            end
            S_BRANCH: begin
                c.alu_a_sel = 3'd1;
                c.alu_op    = 4'd1;
                c.pc_sel    = 3'd1;
            end
            S_JUMP: begin
                c.pc_we = 1'b1;
                if (op == OP_RTYPE && fn == FN_JR) begin
                    c.pc_sel = 3'd3;
                end else begin
                    c.pc_sel = 3'd2;
                end
                // jal links PC (already PC+4) into r31
                if (op == OP_JAL) begin
                    c.reg_we  = 1'b1;
                    c.wb_sel  = 3'd2;
                    c.dst_sel = 3'd2;
                end else begin
                    c.reg_we  = 1'b0;
                end
            end
            S_ADDIEX: begin
                c.alu_a_sel = 3'd1;
                c.alu_b_sel = 3'd2;
            end
            S_IWB: c.reg_we = 1'b1;
            S_TRAP: begin
                c.pc_sel  = 3'd4;
                c.pc_we   = 1'b1;
                c.illegal = 1'b1;
            end
            default: c = {$bits(ctrl_t){1'b0}};
        endcase
        return c;
    endfunction

    state_t state_r;
    state_t state_next_s;
    ctrl_t  ctrl_r;

    // Next-state selection.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (io_mem_ready) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (io_opcode)
                    OP_RTYPE: begin
                        if (io_funct == FN_JR) begin
                            state_next_s = S_JUMP;
                        end else begin
                            state_next_s = S_EXEC;
                        end
                    end
                    OP_LW, OP_SW:   state_next_s = S_MEMADR;
                    OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                    OP_J, OP_JAL:   state_next_s = S_JUMP;
                    OP_ADDI:        state_next_s = S_ADDIEX;
                    default: begin
                        // unknown opcode: trap, or silently retire as a NOP
                        if (EXC_ENABLE) begin
                            state_next_s = S_TRAP;
                        end else begin
                            state_next_s = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                if (io_opcode == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (io_mem_ready) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (io_mem_ready) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_EXEC:   state_next_s = S_RWB;
            S_ADDIEX: state_next_s = S_IWB;
            default:  state_next_s = S_FETCH;
        endcase
    end

    // State register plus registered Moore control word for that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_S;
            ctrl_r  <= decode_ctrl(RESET_S, 6'd0, 6'd0);
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= decode_ctrl(state_next_s, io_opcode, io_funct);
        end
    end

    // Output stage: quiet control word while in reset, otherwise the
    // registered word plus the ready/zero-qualified enables.
    always_comb begin
        io_state = state_r;
        if (!rst_n) begin
            // reset must cut every write/request immediately, not at the next edge
            io_pc_sel    = 3'd0;
            io_alu_a_sel = 3'd0;
            io_alu_b_sel = 3'd1;
            io_wb_sel    = 3'd0;
            io_dst_sel   = 3'd0;
            io_alu_op    = 4'd0;
            io_iord      = 1'b0;
            io_mem_req   = 1'b0;
            io_mem_we    = 1'b0;
            io_ir_we     = 1'b0;
            io_pc_we     = 1'b0;
            io_reg_we    = 1'b0;
            io_mdr_we    = 1'b0;
            io_illegal   = 1'b0;
        end else begin
            io_pc_sel    = ctrl_r.pc_sel;
            io_alu_a_sel = ctrl_r.alu_a_sel;
            io_alu_b_sel = ctrl_r.alu_b_sel;
            io_wb_sel    = ctrl_r.wb_sel;
            io_dst_sel   = ctrl_r.dst_sel;
            io_alu_op    = ctrl_r.alu_op;
            io_iord      = ctrl_r.iord;
            io_mem_req   = ctrl_r.mem_req;
            io_mem_we    = ctrl_r.mem_we;
            io_reg_we    = ctrl_r.reg_we;
            io_illegal   = ctrl_r.illegal;
            io_ir_we     = (state_r == S_FETCH) & io_mem_ready;
            io_mdr_we    = (state_r == S_MEMRD) & io_mem_ready;
            case (state_r)
                S_FETCH:  io_pc_we = io_mem_ready;
                S_BRANCH: io_pc_we = (io_opcode == OP_BNE) ? ~io_zero : io_zero;
                default:  io_pc_we = ctrl_r.pc_we;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: two instances (traps enabled / disabled), each
// tracked by an instruction-level model that expands every instruction into
// its list of control steps and consumes one step per cycle unless that step
// is waiting on memory.
module tb_multi_cycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] opc [2];
    logic [5:0] fn  [2];
    logic       rdy [2];
    logic       zr  [2];

    logic [2:0] pc_sel [2];
    logic [2:0] a_sel  [2];
    logic [2:0] b_sel  [2];
    logic [2:0] wb_sel [2];
    logic [2:0] dst_sel[2];
    logic [3:0] alu_op [2];
    logic [3:0] st     [2];
    logic       iord [2];
    logic       req  [2];
    logic       mwe  [2];
    logic       irwe [2];
    logic       pcwe [2];
    logic       regwe[2];
    logic       mdrwe[2];
    logic       ill  [2];

    multi_cycle_ctrl #(.RESET_STATE(4'd0), .EXC_ENABLE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .io_opcode(opc[0]), .io_funct(fn[0]),
        .io_zero(zr[0]), .io_mem_ready(rdy[0]),
        .io_pc_sel(pc_sel[0]), .io_alu_a_sel(a_sel[0]), .io_alu_b_sel(b_sel[0]),
        .io_wb_sel(wb_sel[0]), .io_dst_sel(dst_sel[0]), .io_alu_op(alu_op[0]),
        .io_iord(iord[0]), .io_mem_req(req[0]), .io_mem_we(mwe[0]),
        .io_ir_we(irwe[0]), .io_pc_we(pcwe[0]), .io_reg_we(regwe[0]),
        .io_mdr_we(mdrwe[0]), .io_illegal(ill[0]), .io_state(st[0]));

    multi_cycle_ctrl #(.RESET_STATE(4'd0), .EXC_ENABLE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .io_opcode(opc[1]), .io_funct(fn[1]),
        .io_zero(zr[1]), .io_mem_ready(rdy[1]),
        .io_pc_sel(pc_sel[1]), .io_alu_a_sel(a_sel[1]), .io_alu_b_sel(b_sel[1]),
        .io_wb_sel(wb_sel[1]), .io_dst_sel(dst_sel[1]), .io_alu_op(alu_op[1]),
        .io_iord(iord[1]), .io_mem_req(req[1]), .io_mem_we(mwe[1]),
        .io_ir_we(irwe[1]), .io_pc_we(pcwe[1]), .io_reg_we(regwe[1]),
        .io_mdr_we(mdrwe[1]), .io_illegal(ill[1]), .io_state(st[1]));

    int n_chk = 0;
    int n_err = 0;

    // remaining steps of the current instruction, per instance
    int q0[$];
    int q1[$];

    int cyc[2], irc[2], pcc[2], rgc[2], mdc[2], ilc[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // an idle instance waits in FETCH
    function automatic int qhead(input int k);
        if (k == 0) return (q0.size() > 0) ? q0[0] : 0;
        return (q1.size() > 0) ? q1[0] : 0;
    endfunction

    task automatic qpush(input int k, input int v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qclear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    // Expand an instruction into its step list (step number == state code).
    task automatic issue(input int k, input logic [5:0] op, input logic [5:0] f);
        opc[k] = op;
        fn[k]  = f;
        qclear(k);
        qpush(k, 0);
        qpush(k, 1);
        if (op == 6'h00 && f == 6'h08) qpush(k, 9);
        else if (op == 6'h00) begin qpush(k, 6); qpush(k, 7); end
        else if (op == 6'h23) begin qpush(k, 2); qpush(k, 3); qpush(k, 4); end
        else if (op == 6'h2B) begin qpush(k, 2); qpush(k, 5); end
        else if (op == 6'h04 || op == 6'h05) qpush(k, 8);
        else if (op == 6'h02 || op == 6'h03) qpush(k, 9);
        else if (op == 6'h08) begin qpush(k, 10); qpush(k, 11); end
        else if (k == 0) qpush(k, 12);
    endtask

    // Expected control vector for a step; step -1 means "in reset".
    function automatic logic [31:0] exp_vec(input int s, input logic [5:0] op,
                                            input logic [5:0] f, input logic r,
                                            input logic z);
        logic [2:0] ps, a, b, wb, ds;
        logic [3:0] ao, sv;
        logic io, rq, we, ir, pw, rw, mw, il;
        {ps, a, b, wb, ds} = 15'd0;
        ao = 4'd0;
        {io, rq, we, ir, pw, rw, mw, il} = 8'd0;
        sv = (s < 0) ? 4'd0 : 4'(s);
        case (s)
            -1: b = 3'd1;
            0:  begin rq = 1'b1; b = 3'd1; ir = r; pw = r; end
            1:  b = 3'd3;
            2:  begin a = 3'd1; b = 3'd2; end
            3:  begin rq = 1'b1; io = 1'b1; mw = r; end
            4:  begin rw = 1'b1; wb = 3'd1; end
            5:  begin rq = 1'b1; we = 1'b1; io = 1'b1; end
            6:  begin a = 3'd1; ao = 4'd2; end
            7:  begin rw = 1'b1; ds = 3'd1; end
            8:  begin a = 3'd1; ao = 4'd1; ps = 3'd1; pw = (op == 6'h04) ? z : ~z; end
            9:  begin
                    pw = 1'b1;
                    ps = (op == 6'h00 && f == 6'h08) ? 3'd3 : 3'd2;
                    if (op == 6'h03) begin rw = 1'b1; wb = 3'd2; ds = 3'd2; end
                end
            10: begin a = 3'd1; b = 3'd2; end
            11: rw = 1'b1;
            12: begin ps = 3'd4; pw = 1'b1; il = 1'b1; end
            default: sv = 4'hF;
        endcase
        return {1'b0, ps, a, b, wb, ds, ao, io, rq, we, ir, pw, rw, mw, il, sv};
    endfunction

    function automatic logic [31:0] act_vec(input int k);
        return {1'b0, pc_sel[k], a_sel[k], b_sel[k], wb_sel[k], dst_sel[k], alu_op[k],
                iord[k], req[k], mwe[k], irwe[k], pcwe[k], regwe[k], mdrwe[k], ill[k], st[k]};
    endfunction

    // One clock: compare both instances mid-cycle, then let the model advance
    // on the rising edge. Inputs are already set by the caller.
    task automatic step();
        int h;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ctrl_vec dut%0d step%0d", k, qhead(k)), act_vec(k),
                exp_vec(qhead(k), opc[k], fn[k], rdy[k], zr[k]));
            if (qsize(k) > 0) begin
                cyc[k]++;
                irc[k] += int'(irwe[k]);
                pcc[k] += int'(pcwe[k]);
                rgc[k] += int'(regwe[k]);
                mdc[k] += int'(mdrwe[k]);
                ilc[k] += int'(ill[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (qsize(k) > 0) begin
                h = qhead(k);
                if (!((h == 0 || h == 3 || h == 5) && !rdy[k])) qpop(k);
            end
        end
        #1;
    endtask

    // Run one instruction on both instances with a given number of wait
    // cycles in FETCH and in the memory-data step; ready is random elsewhere.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input int fw, input int mw);
        int fcnt[2];
        int mcnt[2];
        int h;
        for (int k = 0; k < 2; k++) begin
            {cyc[k], irc[k], pcc[k], rgc[k], mdc[k], ilc[k]} = {6{32'd0}};
            fcnt[k] = 0;
            mcnt[k] = 0;
            issue(k, op, f);
        end
        for (int n = 0; n < 40 && (qsize(0) > 0 || qsize(1) > 0); n++) begin
            for (int k = 0; k < 2; k++) begin
                zr[k] = z;
                h = qhead(k);
                if (qsize(k) == 0) rdy[k] = 1'b0;
                else if (h == 0) begin
                    rdy[k] = (fcnt[k] >= fw);
                    if (fcnt[k] < fw) fcnt[k]++;
                end else if (h == 3 || h == 5) begin
                    rdy[k] = (mcnt[k] >= mw);
                    if (mcnt[k] < mw) mcnt[k]++;
                end else rdy[k] = 1'($urandom_range(0, 1));
            end
            step();
        end
        chk("run_instr budget", 32'(qsize(0) + qsize(1)), 32'd0);
    endtask

    task automatic issue_random(input int k);
        logic [5:0] op;
        logic [5:0] f;
        f = 6'($urandom_range(0, 63));
        case ($urandom_range(0, 9))
            0: begin op = 6'h00; f = 6'h20 + 6'($urandom_range(0, 10)); end
            1: begin op = 6'h00; f = 6'h08; end
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h05;
            6: op = 6'h02;
            7: op = 6'h03;
            8: op = 6'h08;
            default: begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B});
            end
        endcase
        issue(k, op, f);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            opc[k] = 6'd0; fn[k] = 6'd0; rdy[k] = 1'b1; zr[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset vec dut%0d", k), act_vec(k), exp_vec(-1, 6'd0, 6'd0, 1'b1, 1'b0));
        chk("reset alu_b_sel", 32'(b_sel[0]), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // R-type add: 0,1,6,7
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        chk("rtype cycles", 32'(cyc[0]), 32'd4);
        chk("rtype reg_we count", 32'(rgc[0]), 32'd1);
        // lw with 2 fetch waits and 3 memory waits
        run_instr(6'h23, 6'h00, 1'b0, 2, 3);
        chk("lw cycles", 32'(cyc[0]), 32'd10);
        chk("lw ir_we count", 32'(irc[0]), 32'd1);
        chk("lw mdr_we count", 32'(mdc[0]), 32'd1);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0);
        chk("sw cycles", 32'(cyc[0]), 32'd4);
        // branches: pc_we counts include the fetch
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        chk("beq taken pc_we", 32'(pcc[0]), 32'd2);
        chk("beq cycles", 32'(cyc[0]), 32'd3);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        chk("beq not taken pc_we", 32'(pcc[0]), 32'd1);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        chk("bne zero pc_we", 32'(pcc[0]), 32'd1);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0);
        chk("bne nonzero pc_we", 32'(pcc[0]), 32'd2);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);
        chk("jal reg_we count", 32'(rgc[0]), 32'd1);
        chk("jal cycles", 32'(cyc[0]), 32'd3);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);
        chk("jr reg_we count", 32'(rgc[0]), 32'd0);
        run_instr(6'h08, 6'h11, 1'b0, 0, 0);
        chk("addi cycles", 32'(cyc[0]), 32'd4);
        // illegal opcode: trap vs. silent NOP
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        chk("trap illegal pulses", 32'(ilc[0]), 32'd1);
        chk("trap cycles", 32'(cyc[0]), 32'd3);
        chk("nop cycles", 32'(cyc[1]), 32'd2);
        chk("nop illegal pulses", 32'(ilc[1]), 32'd0);
        chk("nop pc_we count", 32'(pcc[1]), 32'd1);
        chk("nop reg_we count", 32'(rgc[1]), 32'd0);

        // reset while a store is stalled in MEMWR
        for (int k = 0; k < 2; k++) issue(k, 6'h2B, 6'h00);
        n = 0;
        while (qhead(0) != 5 && n < 20) begin
            for (int k = 0; k < 2; k++) rdy[k] = (qhead(k) != 5);
            step();
            n++;
        end
        for (int k = 0; k < 2; k++) rdy[k] = 1'b0;
        step();
        chk("memwr req before reset", 32'(req[0]), 32'd1);
        chk("memwr we before reset", 32'(mwe[0]), 32'd1);
        for (int k = 0; k < 2; k++) rdy[k] = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async reset vec dut%0d", k), act_vec(k),
                exp_vec(-1, opc[k], fn[k], 1'b1, 1'b0));
            chk($sformatf("async reset mem_req dut%0d", k), 32'(req[k]), 32'd0);
            chk($sformatf("async reset state dut%0d", k), 32'(st[k]), 32'd0);
        end
        @(posedge clk);
        #1 chk("held reset vec", act_vec(0), exp_vec(-1, opc[0], fn[0], 1'b1, 1'b0));
        #2 rst_n = 1'b1;
        qclear(0);
        qclear(1);
        #1 chk("fresh fetch req", 32'(req[0]), 32'd1);
        run_instr(6'h00, 6'h22, 1'b0, 1, 0);
        chk("post-reset rtype cycles", 32'(cyc[0]), 32'd5);

        // randomized instruction streams
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (qsize(k) == 0) issue_random(k);
                rdy[k] = ($urandom_range(0, 3) != 0);
                zr[k]  = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
